// File: rtl/traffic_gen_if.sv
// traffic_gen_if: flit stream from the generator to the downstream sink
interface traffic_gen_if #(
   parameter int DEST_W = 14,
   parameter int VC_W   = 2
);
   logic              valid;
   logic              ready;
   logic              head;
   logic              tail;
   logic [VC_W-1:0]   vc;
   logic [DEST_W-1:0] dst;
   modport master (output valid, head, tail, vc, dst, input ready);
   modport slave  (input valid, head, tail, vc, dst, output ready);
endinterface

// File: rtl/traffic_gen.sv
// traffic_gen: replays a table of packet descriptors as a flit stream with optional inter-packet gaps
module traffic_gen #(
   parameter int DEPTH   = 1024,
   parameter int DEST_W  = 14,
   parameter int VC_W    = 2,
   parameter int NFLIT_W = 10,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fill_en,
   input  logic [DEST_W-1:0]  fill_dst,
   input  logic [VC_W-1:0]    fill_vc,
   input  logic [NFLIT_W-1:0] fill_nflit,
   input  logic               clear,
   input  logic               start,
   input  logic [CNT_W-1:0]   total_pkts,
   input  logic [7:0]         gap,
   traffic_gen_if.master      flit,
   output logic               table_full,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   pkts_sent
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
   state_t state, state_n;
   logic [DEST_W-1:0]  dst_mem [DEPTH];
   logic [VC_W-1:0]    vc_mem [DEPTH];
   logic [NFLIT_W-1:0] nf_mem [DEPTH];
   logic [AW:0]        count, count_n, new_count, head_inc;
   logic [AW-1:0]      head, head_n, head_wrap, ld_idx;
   logic [CNT_W-1:0]   pkts_n, tot_r, tot_n;
   logic [NFLIT_W-1:0] flits_left, fl_n, ld_nf;
   logic [7:0]         gap_r, gap_n, gap_cnt, gap_cnt_n;
   logic               fh_n, ft_n, load, fill_ok, clr, byp;
   logic [VC_W-1:0]    vc_n, ld_vc;
   logic [DEST_W-1:0]  dst_n, ld_dst;
   assign table_full = count == (AW+1)'(DEPTH);
   assign busy       = state == SEND || state == GAP;
   assign done       = state == DONE;
   assign flit.valid = state == SEND;
   assign fill_ok    = fill_en && !table_full && !busy && !clear;
   assign clr        = clear && !busy;
   // descriptor table; contents survive reset
   always_ff @(posedge clk) begin
      if (fill_ok) begin
         dst_mem[count[AW-1:0]] <= fill_dst;
         vc_mem[count[AW-1:0]]  <= fill_vc;
         nf_mem[count[AW-1:0]]  <= fill_nflit;
      end
   end
   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end
   // next state and next datapath values; a start in the same cycle as a fill sees the new entry via bypass
   always_comb begin
      state_n   = state;
      count_n   = count;
      head_n    = head;
      pkts_n    = pkts_sent;
      tot_n     = tot_r;
      gap_n     = gap_r;
      gap_cnt_n = gap_cnt;
      fl_n      = flits_left;
      fh_n      = flit.head;
      ft_n      = flit.tail;
      vc_n      = flit.vc;
      dst_n     = flit.dst;
      ld_idx    = head;
      load      = 1'b0;
      new_count = clr ? '0 : count + (AW+1)'(fill_ok);
      head_inc  = {1'b0, head} + (AW+1)'(1);
      head_wrap = head_inc == count ? '0 : head_inc[AW-1:0];
      case (state)
         IDLE, DONE: begin
            count_n = new_count;
            if (clr) state_n = IDLE;
            if (start) begin
               pkts_n = '0;
               tot_n  = total_pkts;
               gap_n  = gap;
               head_n = '0;
               if (total_pkts == '0 || new_count == '0) state_n = DONE;
               else begin
                  state_n = SEND;
                  ld_idx  = '0;
                  load    = 1'b1;
               end
            end
         end
         SEND: begin
            if (flit.ready) begin
               if (flits_left == NFLIT_W'(1)) begin
                  pkts_n = pkts_sent + CNT_W'(1);
                  head_n = head_wrap;
                  if (pkts_n == tot_r) state_n = DONE;
                  else if (gap_r != 8'd0) begin
                     state_n   = GAP;
                     gap_cnt_n = gap_r;
                  end else begin
                     ld_idx = head_wrap;
                     load   = 1'b1;
                  end
               end else begin
                  fl_n = flits_left - NFLIT_W'(1);
                  fh_n = 1'b0;
                  ft_n = flits_left == NFLIT_W'(2);
               end
            end
         end
         GAP: begin
            gap_cnt_n = gap_cnt - 8'd1;
            if (gap_cnt == 8'd1) begin
               state_n = SEND;
               load    = 1'b1;
            end
         end
      endcase
      byp    = fill_ok && count == {1'b0, ld_idx};
      ld_dst = byp ? fill_dst : dst_mem[ld_idx];
      ld_vc  = byp ? fill_vc : vc_mem[ld_idx];
      ld_nf  = byp ? fill_nflit : nf_mem[ld_idx];
      ld_nf  = ld_nf == '0 ? NFLIT_W'(1) : ld_nf;
      if (load) begin
         fl_n  = ld_nf;
         fh_n  = 1'b1;
         ft_n  = ld_nf == NFLIT_W'(1);
         vc_n  = ld_vc;
         dst_n = ld_dst;
      end
   end
   // datapath and registered flit fields
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count      <= '0;
         head       <= '0;
         pkts_sent  <= '0;
         tot_r      <= '0;
         gap_r      <= '0;
         gap_cnt    <= '0;
         flits_left <= '0;
         flit.head  <= 1'b0;
         flit.tail  <= 1'b0;
         flit.vc    <= '0;
         flit.dst   <= '0;
      end else begin
         count      <= count_n;
         head       <= head_n;
         pkts_sent  <= pkts_n;
         tot_r      <= tot_n;
         gap_r      <= gap_n;
         gap_cnt    <= gap_cnt_n;
         flits_left <= fl_n;
         flit.head  <= fh_n;
         flit.tail  <= ft_n;
         flit.vc    <= vc_n;
         flit.dst   <= dst_n;
      end
   end
endmodule
